// File: rtl/jts16_pxlmix_if.sv
// Pixel mixer bus: layer pixels, blanking and priority config in; palette address,
// shadow, delayed blanking and the active priority set out.
interface jts16_pxlmix_if #(
    parameter int LAYERS = 4,
    parameter int PW     = 11
);
    logic                  pxl_cen;
    logic [LAYERS*PW-1:0]  pxl;
    logic [2*LAYERS-1:0]   prio_cfg;
    logic                  prio_we;
    logic                  shd_en;
    logic [LAYERS-1:0]     gfx_en;
    logic                  preLHBL;
    logic                  preLVBL;
    logic [PW-1:0]         pal_addr;
    logic                  shadow;
    logic                  LHBL;
    logic                  LVBL;
    logic [2*LAYERS-1:0]   prio_act;

    modport master (
        output pxl_cen, pxl, prio_cfg, prio_we, shd_en, gfx_en, preLHBL, preLVBL,
        input  pal_addr, shadow, LHBL, LVBL, prio_act
    );

    modport slave (
        input  pxl_cen, pxl, prio_cfg, prio_we, shd_en, gfx_en, preLHBL, preLVBL,
        output pal_addr, shadow, LHBL, LVBL, prio_act
    );
endinterface

// File: rtl/jts16_pxlmix.sv
// Three-stage priority pixel mixer with object-layer shadow resolution.
// Priority writes are double-buffered and only take effect at vblank entry.
module jts16_pxlmix #(
    parameter int             LAYERS   = 4,
    parameter int             PW       = 11,
    parameter logic [PW-1:0]  BACKDROP = '0,
    parameter logic [3:0]     SHD_PEN  = 4'hA
) (
    input  logic           clk,
    input  logic           rst_n,
    jts16_pxlmix_if.slave  bus
);

    function automatic logic [2*LAYERS-1:0] reset_prio();
        logic [2*LAYERS-1:0] r;
        r = '0;
        for (int k = 0; k < LAYERS; k++) r[2*k +: 2] = 2'(k % 4);
        return r;
    endfunction

    localparam logic [2*LAYERS-1:0] PRIO_RST = reset_prio();

    // ---------------- priority double buffer ----------------
    logic [2*LAYERS-1:0] prio_pend;
    logic [2*LAYERS-1:0] prio_act_q;
    logic                lvbl_last;
    logic                vb_entry;

    assign vb_entry = bus.pxl_cen & lvbl_last & ~bus.preLVBL;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_pend <= PRIO_RST;
        end else if (bus.prio_we) begin
            prio_pend <= bus.prio_cfg;
        end
    end

    // A write landing on the vblank-entry tick bypasses the pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_act_q <= PRIO_RST;
            lvbl_last  <= 1'b0;
        end else if (bus.pxl_cen) begin
            lvbl_last <= bus.preLVBL;
            if (vb_entry) prio_act_q <= bus.prio_we ? bus.prio_cfg : prio_pend;
        end
    end

    // ---------------- stage 1: capture ----------------
    logic [LAYERS*PW-1:0] s1_pxl;
    logic [LAYERS-1:0]    s1_opaque;
    logic                 s1_hb, s1_vb;
    logic [LAYERS-1:0]    opaque;

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        opaque = '0;
        for (int k = 0; k < LAYERS; k++)
            opaque[k] = bus.gfx_en[k] && (bus.pxl[k*PW +: 4] != 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pxl    <= '0;
            s1_opaque <= '0;
            s1_hb     <= 1'b0;
            s1_vb     <= 1'b0;
        end else if (bus.pxl_cen) begin
            s1_pxl    <= bus.pxl;
            s1_opaque <= opaque;
            s1_hb     <= bus.preLHBL;
            s1_vb     <= bus.preLVBL;
        end
    end

    // ---------------- stage 2: winner and runner-up ----------------
    logic          win_ok, win_l0, run_ok;
    logic [1:0]    win_prio, run_prio;
    logic [PW-1:0] win_pxl, run_pxl;

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        win_ok   = 1'b0;
        win_l0   = 1'b0;
        win_prio = 2'd0;
        win_pxl  = '0;
        run_ok   = 1'b0;
        run_prio = 2'd0;
        run_pxl  = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (s1_opaque[k] && (!win_ok || prio_act_q[2*k +: 2] > win_prio)) begin
                win_ok   = 1'b1;
                win_l0   = (k == 0);
                win_prio = prio_act_q[2*k +: 2];
                win_pxl  = s1_pxl[k*PW +: PW];
            end
            if (k != 0 && s1_opaque[k] && (!run_ok || prio_act_q[2*k +: 2] > run_prio)) begin
                run_ok   = 1'b1;
                run_prio = prio_act_q[2*k +: 2];
                run_pxl  = s1_pxl[k*PW +: PW];
            end
        end
    end

    logic          s2_win_ok, s2_win_l0, s2_run_ok;
    logic [PW-1:0] s2_win_pxl, s2_run_pxl;
    logic          s2_hb, s2_vb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_win_ok  <= 1'b0;
            s2_win_l0  <= 1'b0;
            s2_win_pxl <= '0;
            s2_run_ok  <= 1'b0;
            s2_run_pxl <= '0;
            s2_hb      <= 1'b0;
            s2_vb      <= 1'b0;
        end else if (bus.pxl_cen) begin
            s2_win_ok  <= win_ok;
            s2_win_l0  <= win_l0;
            s2_win_pxl <= win_pxl;
            s2_run_ok  <= run_ok;
            s2_run_pxl <= run_pxl;
            s2_hb      <= s1_hb;
            s2_vb      <= s1_vb;
        end
    end

    // ---------------- stage 3: shadow resolution and output ----------------
    logic          shade;
    logic [PW-1:0] pal_next;

    assign shade = bus.shd_en & s2_win_ok & s2_win_l0 & (s2_win_pxl[3:0] == SHD_PEN);

    always_comb begin
        pal_next = BACKDROP;
        if (shade)          pal_next = s2_run_ok ? s2_run_pxl : BACKDROP;
        else if (s2_win_ok) pal_next = s2_win_pxl;
    end

    logic [PW-1:0] pal_q;
    logic          shadow_q, hb_q, vb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_q    <= BACKDROP;
            shadow_q <= 1'b0;
            hb_q     <= 1'b0;
            vb_q     <= 1'b0;
        end else if (bus.pxl_cen) begin
            pal_q    <= pal_next;
            shadow_q <= shade;
            hb_q     <= s2_hb;
            vb_q     <= s2_vb;
        end
    end

    assign bus.pal_addr = pal_q;
    assign bus.shadow   = shadow_q;
    assign bus.LHBL     = hb_q;
    assign bus.LVBL     = vb_q;
    assign bus.prio_act = prio_act_q;

endmodule
